// File: rtl/timer_pkg.sv
// Shared types and constants for the 8-bit timer.
// States, clock-select encodings, divide masks, TSR bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT
  } timer_state_e;

  localparam int MASK_W = 4;

  localparam logic [1:0] CKS_DIV2  = 2'b00;
  localparam logic [1:0] CKS_DIV4  = 2'b01;
  localparam logic [1:0] CKS_DIV8  = 2'b10;
  localparam logic [1:0] CKS_DIV16 = 2'b11;

  localparam int TSR_OVF_BIT = 0;
  localparam int TSR_UDF_BIT = 1;

  function automatic logic [MASK_W-1:0] cks_mask(
    input logic [1:0] cks
  );
    logic [MASK_W-1:0] m;
    unique case (cks)
      CKS_DIV2:  m = 4'b0001;
      CKS_DIV4:  m = 4'b0011;
      CKS_DIV8:  m = 4'b0111;
      CKS_DIV16: m = 4'b1111;
      default:   m = 4'b0001;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler producing a one-clk count tick.
// Ports: clk, rst, clear (hold at 0), cks (divide select) in; tick out.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESC_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W-1:0] mask;

  assign mask = PRESC_W'(cks_mask(cks));

  // tick is registered off the pre-increment count, so the
  // first strobe lands a full divide period after clear drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + PRESC_W'(1);
      tick <= ((cnt & mask) == mask);
    end
  end

endmodule

// File: rtl/timer_count_ctrl.sv
// Timer sequencing FSM, TCNT counter and sticky OVF/UDF flags.
// Ports: load/enable/dir/cks/clr controls in; tcnt, tick, flags, tsr out.
module timer_count_ctrl
  import timer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] count_start_value,
  input  logic                  count_load,
  input  logic                  count_enable,
  input  logic                  count_up_down,
  input  logic [1:0]            cks,
  input  logic                  clr_ovf,
  input  logic                  clr_udf,
  output logic [DATA_WIDTH-1:0] tcnt,
  output logic                  tick,
  output logic                  tmr_ovf,
  output logic                  tmr_udf,
  output logic [DATA_WIDTH-1:0] tsr
);

  timer_state_e state;
  timer_state_e state_d;

  logic [DATA_WIDTH-1:0] tcnt_d;
  logic                  ovf_set;
  logic                  udf_set;
  logic                  presc_clr;

  always_comb begin
    state_d = IDLE;
    priority case (1'b1)
      count_load:   state_d = LOAD;
      count_enable: state_d = COUNT;
      default:      state_d = IDLE;
    endcase
  end

  // Clearing on either side of a COUNT boundary keeps tick low
  // outside COUNT and restarts a full period on every entry.
  assign presc_clr = (state != COUNT) || (state_d != COUNT);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clr),
    .cks   (cks),
    .tick  (tick)
  );

  always_comb begin
    tcnt_d  = tcnt;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (state_d == LOAD) begin
      tcnt_d = count_start_value;
    end else if (state_d == COUNT && tick) begin
      if (count_up_down) begin
        tcnt_d  = tcnt + DATA_WIDTH'(1);
        ovf_set = (tcnt == '1);
      end else begin
        tcnt_d  = tcnt - DATA_WIDTH'(1);
        udf_set = (tcnt == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tcnt    <= '0;
      tmr_ovf <= 1'b0;
      tmr_udf <= 1'b0;
    end else begin
      state   <= state_d;
      tcnt    <= tcnt_d;
      tmr_ovf <= ovf_set | (tmr_ovf & ~clr_ovf);
      tmr_udf <= udf_set | (tmr_udf & ~clr_udf);
    end
  end

  always_comb begin
    tsr              = '0;
    tsr[TSR_OVF_BIT] = tmr_ovf;
    tsr[TSR_UDF_BIT] = tmr_udf;
  end

endmodule

// File: tb/tb_timer_count_ctrl.sv
// Self-checking bench for timer_count_ctrl.
// Scoreboard of expected per-tick results, checked task by task.
module tb_timer_count_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count_start_value;
  logic       count_load;
  logic       count_enable;
  logic       count_up_down;
  logic [1:0] cks;
  logic       clr_ovf;
  logic       clr_udf;
  logic [7:0] tcnt;
  logic       tick;
  logic       tmr_ovf;
  logic       tmr_udf;
  logic [7:0] tsr;

  timer_count_ctrl #(
    .DATA_WIDTH (8),
    .PRESC_W    (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .count_start_value (count_start_value),
    .count_load        (count_load),
    .count_enable      (count_enable),
    .count_up_down     (count_up_down),
    .cks               (cks),
    .clr_ovf           (clr_ovf),
    .clr_udf           (clr_udf),
    .tcnt              (tcnt),
    .tick              (tick),
    .tmr_ovf           (tmr_ovf),
    .tmr_udf           (tmr_udf),
    .tsr               (tsr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] tcnt;
    logic       ovf;
    logic       udf;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Gaps are counted in posedges from the negedge where stimulus
  // was driven (or the previous tick was seen) to the tick negedge;
  // entering COUNT costs one edge, so the first gap is period+1.
  task automatic wait_tick(input int lim, output int at,
                           output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (tcnt !== 8'h00 || tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_cnt: tcnt=%h tick=%b want 00 0",
               tcnt, tick);
    end
    total++;
    if (tmr_ovf !== 1'b0 || tmr_udf !== 1'b0 || tsr !== 8'h00) begin
      bad++;
      $display("FAIL reset_flags: ovf=%b udf=%b tsr=%h want 0 0 00",
               tmr_ovf, tmr_udf, tsr);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (tcnt !== 8'h00 || tick !== 1'b0 || tsr !== 8'h00) begin
      bad++;
      $display("FAIL reset_idle: tcnt=%h tick=%b tsr=%h want 00 0 00",
               tcnt, tick, tsr);
    end
  endtask

  task automatic test_load_up();
    exp_t e;
    int last, at;
    bit ok;
    count_start_value = 8'hFD;
    count_load = 1'b1;
    @(negedge clk);
    total++;
    if (tcnt !== 8'hFD) begin
      bad++;
      $display("FAIL load_fd: tcnt=%h want fd", tcnt);
    end
    count_load    = 1'b0;
    count_enable  = 1'b1;
    count_up_down = 1'b1;
    cks           = 2'b00;
    last = cyc;
    sb.push_back('{8'hFE, 1'b0, 1'b0, 3});
    sb.push_back('{8'hFF, 1'b0, 1'b0, 2});
    sb.push_back('{8'h00, 1'b1, 1'b0, 2});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(40, at, ok);
      total++;
      if (!ok || at - last != e.gap) begin
        bad++;
        $display("FAIL up_gap: seen=%b gap=%0d want %0d",
                 ok, at - last, e.gap);
      end
      last = at;
      @(negedge clk);
      total++;
      if (tcnt !== e.tcnt || tmr_ovf !== e.ovf ||
          tmr_udf !== e.udf || tsr !== {6'b0, e.udf, e.ovf}) begin
        bad++;
        $display("FAIL up_val: tcnt=%h ovf=%b udf=%b tsr=%h want %h %b %b",
                 tcnt, tmr_ovf, tmr_udf, tsr, e.tcnt, e.ovf, e.udf);
      end
    end
  endtask

  task automatic test_down();
    exp_t e;
    int last, at;
    bit ok;
    logic [7:0] prev;
    count_start_value = 8'h01;
    count_load = 1'b1;
    clr_ovf    = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    total++;
    if (tcnt !== 8'h01 || tmr_ovf !== 1'b0) begin
      bad++;
      $display("FAIL down_load: tcnt=%h ovf=%b want 01 0",
               tcnt, tmr_ovf);
    end
    count_load    = 1'b0;
    count_up_down = 1'b0;
    cks           = 2'b11;
    last = cyc;
    prev = 8'h01;
    sb.push_back('{8'h00, 1'b0, 1'b0, 17});
    sb.push_back('{8'hFF, 1'b0, 1'b1, 16});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(40, at, ok);
      total++;
      if (!ok || at - last != e.gap) begin
        bad++;
        $display("FAIL down_gap: seen=%b gap=%0d want %0d",
                 ok, at - last, e.gap);
      end
      total++;
      if (tcnt !== prev) begin
        bad++;
        $display("FAIL down_hold: tcnt=%h want %h", tcnt, prev);
      end
      last = at;
      @(negedge clk);
      total++;
      if (tcnt !== e.tcnt || tmr_ovf !== e.ovf ||
          tmr_udf !== e.udf || tsr !== {6'b0, e.udf, e.ovf}) begin
        bad++;
        $display("FAIL down_val: tcnt=%h ovf=%b udf=%b tsr=%h want %h %b %b",
                 tcnt, tmr_ovf, tmr_udf, tsr, e.tcnt, e.ovf, e.udf);
      end
      prev = e.tcnt;
    end
  endtask

  task automatic test_flag_race();
    int at;
    bit ok;
    count_start_value = 8'hFF;
    count_load    = 1'b1;
    count_up_down = 1'b1;
    cks           = 2'b00;
    @(negedge clk);
    count_load = 1'b0;
    wait_tick(20, at, ok);
    @(negedge clk);
    total++;
    if (!ok || tcnt !== 8'h00 || tmr_ovf !== 1'b1) begin
      bad++;
      $display("FAIL race_setup: seen=%b tcnt=%h ovf=%b want 1 00 1",
               ok, tcnt, tmr_ovf);
    end
    count_load = 1'b1;
    @(negedge clk);
    count_load = 1'b0;
    wait_tick(20, at, ok);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    total++;
    if (!ok || tcnt !== 8'h00 || tmr_ovf !== 1'b1) begin
      bad++;
      $display("FAIL race_setwins: seen=%b tcnt=%h ovf=%b want 1 00 1",
               ok, tcnt, tmr_ovf);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    total++;
    if (tmr_ovf !== 1'b0 || tmr_udf !== 1'b1 || tsr !== 8'h02) begin
      bad++;
      $display("FAIL race_clr_ovf: ovf=%b udf=%b tsr=%h want 0 1 02",
               tmr_ovf, tmr_udf, tsr);
    end
    clr_udf = 1'b1;
    @(negedge clk);
    clr_udf = 1'b0;
    total++;
    if (tmr_ovf !== 1'b0 || tmr_udf !== 1'b0 || tsr !== 8'h00) begin
      bad++;
      $display("FAIL race_clr_udf: ovf=%b udf=%b tsr=%h want 0 0 00",
               tmr_ovf, tmr_udf, tsr);
    end
  endtask

  task automatic test_load_priority();
    exp_t e;
    int last, at;
    bit ok;
    logic [7:0] want;
    int errs;
    errs = 0;
    count_load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      want = (i < 5) ? 8'h7F : 8'h80;
      count_start_value = want;
      @(negedge clk);
      if (tcnt !== want || tick !== 1'b0) begin
        errs++;
        $display("FAIL prio_hold: cyc %0d tcnt=%h tick=%b want %h 0",
                 i, tcnt, tick, want);
      end
    end
    total++;
    if (errs != 0) bad++;
    count_load = 1'b0;
    last = cyc;
    sb.push_back('{8'h81, 1'b0, 1'b0, 3});
    sb.push_back('{8'h82, 1'b0, 1'b0, 2});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(40, at, ok);
      total++;
      if (!ok || at - last != e.gap) begin
        bad++;
        $display("FAIL prio_gap: seen=%b gap=%0d want %0d",
                 ok, at - last, e.gap);
      end
      last = at;
      @(negedge clk);
      total++;
      if (tcnt !== e.tcnt || tmr_ovf !== e.ovf || tmr_udf !== e.udf) begin
        bad++;
        $display("FAIL prio_val: tcnt=%h ovf=%b udf=%b want %h %b %b",
                 tcnt, tmr_ovf, tmr_udf, e.tcnt, e.ovf, e.udf);
      end
    end
  endtask

  task automatic test_pause_cks();
    exp_t e;
    int last, at;
    bit ok;
    int errs;
    errs = 0;
    count_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tcnt !== 8'h82 || tick !== 1'b0) begin
        errs++;
        $display("FAIL pause_hold: cyc %0d tcnt=%h tick=%b want 82 0",
                 i, tcnt, tick);
      end
    end
    total++;
    if (errs != 0) bad++;
    count_enable = 1'b1;
    last = cyc;
    sb.push_back('{8'h83, 1'b0, 1'b0, 3});
    sb.push_back('{8'h84, 1'b0, 1'b0, 2});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(40, at, ok);
      total++;
      if (!ok || at - last != e.gap) begin
        bad++;
        $display("FAIL resume_gap: seen=%b gap=%0d want %0d",
                 ok, at - last, e.gap);
      end
      last = at;
      @(negedge clk);
      total++;
      if (tcnt !== e.tcnt) begin
        bad++;
        $display("FAIL resume_val: tcnt=%h want %h", tcnt, e.tcnt);
      end
    end
    cks  = 2'b10;
    last = cyc;
    wait_tick(12, at, ok);
    total++;
    if (!ok || at - last < 2 || at - last > 8) begin
      bad++;
      $display("FAIL cks_first: seen=%b gap=%0d want 2..8",
               ok, at - last);
    end
    last = at;
    @(negedge clk);
    total++;
    if (tcnt !== 8'h85) begin
      bad++;
      $display("FAIL cks_first_val: tcnt=%h want 85", tcnt);
    end
    sb.push_back('{8'h86, 1'b0, 1'b0, 8});
    sb.push_back('{8'h87, 1'b0, 1'b0, 8});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(40, at, ok);
      total++;
      if (!ok || at - last != e.gap) begin
        bad++;
        $display("FAIL cks_gap: seen=%b gap=%0d want %0d",
                 ok, at - last, e.gap);
      end
      last = at;
      @(negedge clk);
      total++;
      if (tcnt !== e.tcnt) begin
        bad++;
        $display("FAIL cks_val: tcnt=%h want %h", tcnt, e.tcnt);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int last, at;
    bit ok;
    count_start_value = 8'hFF;
    count_load    = 1'b1;
    count_up_down = 1'b1;
    cks           = 2'b00;
    @(negedge clk);
    count_load = 1'b0;
    wait_tick(20, at, ok);
    @(negedge clk);
    count_start_value = 8'h00;
    count_load    = 1'b1;
    count_up_down = 1'b0;
    @(negedge clk);
    count_load = 1'b0;
    wait_tick(20, at, ok);
    @(negedge clk);
    count_start_value = 8'h37;
    count_load = 1'b1;
    @(negedge clk);
    count_load = 1'b0;
    total++;
    if (tcnt !== 8'h37 || tmr_ovf !== 1'b1 || tmr_udf !== 1'b1) begin
      bad++;
      $display("FAIL arst_setup: tcnt=%h ovf=%b udf=%b want 37 1 1",
               tcnt, tmr_ovf, tmr_udf);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (tcnt !== 8'h00 || tick !== 1'b0 || tmr_ovf !== 1'b0 ||
        tmr_udf !== 1'b0 || tsr !== 8'h00) begin
      bad++;
      $display("FAIL arst_now: tcnt=%h tick=%b ovf=%b udf=%b tsr=%h want 0",
               tcnt, tick, tmr_ovf, tmr_udf, tsr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_up_down = 1'b1;
    last = cyc;
    sb.push_back('{8'h01, 1'b0, 1'b0, 3});
    sb.push_back('{8'h02, 1'b0, 1'b0, 2});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(40, at, ok);
      total++;
      if (!ok || at - last != e.gap) begin
        bad++;
        $display("FAIL arst_gap: seen=%b gap=%0d want %0d",
                 ok, at - last, e.gap);
      end
      last = at;
      @(negedge clk);
      total++;
      if (tcnt !== e.tcnt || tsr !== 8'h00) begin
        bad++;
        $display("FAIL arst_val: tcnt=%h tsr=%h want %h 00",
                 tcnt, tsr, e.tcnt);
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    count_start_value = 8'h00;
    count_load        = 1'b0;
    count_enable      = 1'b0;
    count_up_down     = 1'b0;
    cks               = 2'b00;
    clr_ovf           = 1'b0;
    clr_udf           = 1'b0;
    test_reset();
    test_load_up();
    test_down();
    test_flag_race();
    test_load_priority();
    test_pause_cks();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t want finish before 200000", $time);
    $fatal(1);
  end

endmodule
